pick_best_mode_rd: RTL

- Rate-distortion mode decision stage directly downstream of the SSE engine (start/a/b in, sse/done out).
- Evaluates NUM_MODES candidate prediction blocks against one source block, one at a time:
  - drives the SSE engine for each candidate;
  - computes an RD score per candidate;
  - reports the lowest-score mode with its SSE and score.
- Sits between intra-prediction generation and the macroblock mode/residual stage.

---
 rtl/pick_best_mode_rd.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pick_best_mode_rd.sv
// ============================================================================
// Module   : pick_best_mode_rd
// Purpose  : Rate-distortion mode decision. Drives an external SSE engine once
//            per candidate prediction and keeps the lowest-RD-score mode.
//            Optional macro: PICK_BEST_ZERO_SSE_EXIT_EN (stop early on a
//            zero-SSE, zero-rate candidate).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pick_best_mode_rd #(
  parameter int NUM_MODES    = 4,
  parameter int BIT_WIDTH    = 8,
  parameter int BLOCK_SIZE   = 16,
  parameter int RATE_WIDTH   = 16,
  parameter int LAMBDA_WIDTH = 16,
  parameter int DISTO_SHIFT  = 8,
  localparam int BLK_W = BIT_WIDTH * BLOCK_SIZE * BLOCK_SIZE,
  localparam int IDX_W = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [BLK_W-1:0]                src,
  input  logic [NUM_MODES*BLK_W-1:0]      preds,
  input  logic [NUM_MODES*RATE_WIDTH-1:0] rates,
  input  logic [LAMBDA_WIDTH-1:0]         lambda,
  output logic                            sse_start,
  output logic [BLK_W-1:0]                sse_a,
  output logic [BLK_W-1:0]                sse_b,
  input  logic [31:0]                     sse_in,
  input  logic                            sse_done,
  output logic [IDX_W-1:0]                best_mode,
  output logic [31:0]                     best_sse,
  output logic [47:0]                     best_score,
  output logic                            done
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(NUM_MODES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_SCORE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                  r_state;
  logic [IDX_W-1:0]        r_idx;
  logic [LAMBDA_WIDTH-1:0] r_lambda;
  logic [31:0]             r_sse;

  logic [IDX_W-1:0]        w_idx_next;
  logic [RATE_WIDTH-1:0]   w_rate;
  logic [BLK_W-1:0]        w_pred_next;
  logic [47:0]             w_disto;
  logic [47:0]             w_rate_cost;
  logic [47:0]             w_score;
  logic                    w_take;
  logic                    w_last;

  assign sse_a      = src;
  assign w_idx_next = r_idx + IDX_W'(1);

  // Mode selects written as decoders so the index never needs widening.
  always_comb begin
    w_rate = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_rate = rates[k*RATE_WIDTH +: RATE_WIDTH];
      end
    end
  end

  always_comb begin
    w_pred_next = '0;
    for (int k = 0; k < NUM_MODES; k++) begin
      if (w_idx_next == IDX_W'(k)) begin
        w_pred_next = preds[k*BLK_W +: BLK_W];
      end
    end
  end

  assign w_disto     = {16'd0, r_sse} << DISTO_SHIFT;
  assign w_rate_cost = 48'(r_lambda) * 48'(w_rate);
  assign w_score     = w_disto + w_rate_cost;

`ifdef PICK_BEST_ZERO_SSE_EXIT_EN
  logic w_zero;
  assign w_zero = (r_sse == 32'd0) && (w_rate == '0);
  assign w_take = (r_idx == '0) || (w_score < best_score) || w_zero;
  assign w_last = (r_idx == c_last_idx) || w_zero;
`else
  assign w_take = (r_idx == '0) || (w_score < best_score);
  assign w_last = (r_idx == c_last_idx);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_lambda   <= '0;
      r_sse      <= '0;
      sse_start  <= 1'b0;
      sse_b      <= '0;
      best_mode  <= '0;
      best_sse   <= '0;
      best_score <= '0;
      done       <= 1'b0;
    end else begin
      sse_start <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx     <= '0;
            r_lambda  <= lambda;
            sse_b     <= preds[BLK_W-1:0];
            sse_start <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (sse_done) begin
            r_sse   <= sse_in;
            r_state <= S_SCORE;
          end
        end
        S_SCORE: begin
          // Strict compare: on equal scores the lower index stays best.
          if (w_take) begin
            best_mode  <= r_idx;
            best_sse   <= r_sse;
            best_score <= w_score;
          end
          if (w_last) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx     <= w_idx_next;
            sse_b     <= w_pred_next;
            sse_start <= 1'b1;
            r_state   <= S_ISSUE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
